// File: rtl/latch_ctrl_seq_if.sv
// latch_ctrl_seq_if
// Request/status bundle between a requester and the latch control sequencer.
//   REQ_VALID  requester -> sequencer  request valid
//   REQ_OP     requester -> sequencer  00 write, 01 set, 10 reset, 11 reserved
//   REQ_DATA   requester -> sequencer  write data (op 00 only)
//   REQ_READY  sequencer -> requester  high only in IDLE
//   DONE       sequencer -> requester  one-cycle completion pulse
//   ERR        sequencer -> requester  one-cycle pulse for reserved op
//   BUSY       sequencer -> requester  high whenever not IDLE
interface latch_ctrl_seq_if;
  logic       REQ_VALID;
  logic [1:0] REQ_OP;
  logic       REQ_DATA;
  logic       REQ_READY;
  logic       DONE;
  logic       ERR;
  logic       BUSY;

  modport master (
    output REQ_VALID, REQ_OP, REQ_DATA,
    input  REQ_READY, DONE, ERR, BUSY
  );

  modport slave (
    input  REQ_VALID, REQ_OP, REQ_DATA,
    output REQ_READY, DONE, ERR, BUSY
  );
endinterface

// File: rtl/latch_ctrl_seq.sv
// latch_ctrl_seq
// Sequences the control pins of a set/reset gated latch from a valid/ready
// request port, enforcing gate width, set/reset pulse width and recovery time.
// Ports:
//   CLK       clock, rising edge
//   RST       synchronous active-high reset
//   req       request/status bundle (slave side)
//   LAT_D     latch data pin
//   LAT_CLK   latch gate, transparent high
//   LAT_SETB  latch set, active low
//   LAT_RSTB  latch reset, active low
// All outputs are registered.
module latch_ctrl_seq #(
  parameter int unsigned GATE_CYC = 1,
  parameter int unsigned PW_CYC   = 2,
  parameter int unsigned REC_CYC  = 1
) (
  input  logic            CLK,
  input  logic            RST,
  latch_ctrl_seq_if.slave req,
  output logic            LAT_D,
  output logic            LAT_CLK,
  output logic            LAT_SETB,
  output logic            LAT_RSTB
);

  localparam int unsigned MAX_GP  = (GATE_CYC > PW_CYC) ? GATE_CYC : PW_CYC;
  localparam int unsigned MAX_CYC = (MAX_GP > REC_CYC) ? MAX_GP : REC_CYC;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);

  // Counter holds "remaining cycles - 1" so the state exits when it reads 0.
  localparam logic [CW-1:0] GATE_LD = CW'(GATE_CYC - 1);
  localparam logic [CW-1:0] PW_LD   = CW'(PW_CYC - 1);
  localparam logic [CW-1:0] REC_LD  = CW'(REC_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_GATE,
    S_HOLD,
    S_ASSERT,
    S_RECOVER
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_ready;
  logic          r_done;
  logic          r_err;
  logic          r_err_pend;
  logic          r_busy;
  logic          r_d;
  logic          r_clk;
  logic          r_setb;
  logic          r_rstb;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_ready    <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_pend <= 1'b0;
      r_busy     <= 1'b0;
      r_d        <= 1'b0;
      r_clk      <= 1'b0;
      r_setb     <= 1'b1;
      r_rstb     <= 1'b1;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b1;
          // r_ready is only ever high in IDLE, so it doubles as the accept gate.
          if (r_ready && req.REQ_VALID) begin
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            case (req.REQ_OP)
              2'b00: begin
                r_d     <= req.REQ_DATA;
                r_state <= S_SETUP;
              end
              2'b01: begin
                r_d     <= 1'b1;
                r_setb  <= 1'b0;
                r_cnt   <= PW_LD;
                r_state <= S_ASSERT;
              end
              2'b10: begin
                r_d     <= 1'b0;
                r_rstb  <= 1'b0;
                r_cnt   <= PW_LD;
                r_state <= S_ASSERT;
              end
              default: begin
                // Reserved op reuses HOLD: one idle-pin cycle, then DONE+ERR.
                r_err_pend <= 1'b1;
                r_state    <= S_HOLD;
              end
            endcase
          end
        end
        S_SETUP: begin
          r_clk   <= 1'b1;
          r_cnt   <= GATE_LD;
          r_state <= S_GATE;
        end
        S_GATE: begin
          if (r_cnt == '0) begin
            r_clk   <= 1'b0;
            r_state <= S_HOLD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_HOLD: begin
          r_done     <= 1'b1;
          r_err      <= r_err_pend;
          r_err_pend <= 1'b0;
          r_ready    <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
        S_ASSERT: begin
          if (r_cnt == '0) begin
            r_setb  <= 1'b1;
            r_rstb  <= 1'b1;
            r_cnt   <= REC_LD;
            r_state <= S_RECOVER;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_RECOVER: begin
          if (r_cnt == '0) begin
            r_done  <= 1'b1;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req.REQ_READY = r_ready;
  assign req.DONE      = r_done;
  assign req.ERR       = r_err;
  assign req.BUSY      = r_busy;
  assign LAT_D         = r_d;
  assign LAT_CLK       = r_clk;
  assign LAT_SETB      = r_setb;
  assign LAT_RSTB      = r_rstb;

endmodule

// File: tb/tb_latch_ctrl_seq.sv
module tb_latch_ctrl_seq;
  localparam int unsigned G = 1;
  localparam int unsigned P = 2;
  localparam int unsigned R = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  latch_ctrl_seq_if bus ();
  logic lat_d, lat_clk, lat_setb, lat_rstb;

  latch_ctrl_seq #(.GATE_CYC(G), .PW_CYC(P), .REC_CYC(R)) dut (
    .CLK      (clk),
    .RST      (rst),
    .req      (bus),
    .LAT_D    (lat_d),
    .LAT_CLK  (lat_clk),
    .LAT_SETB (lat_setb),
    .LAT_RSTB (lat_rstb)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Operation-level model: an op is a timeline of t = 1..latency cycles
  // after acceptance, followed by an idle DONE cycle.
  bit          m_busy  = 1'b0;
  bit          m_ready = 1'b0;
  bit          m_done  = 1'b0;
  bit          m_err   = 1'b0;
  bit          m_d     = 1'b0;
  int unsigned m_t     = 0;
  logic [1:0]  m_op    = 2'b00;
  bit          p_clk   = 1'b0;
  bit          p_d     = 1'b0;
  int          ndone;

  task automatic chk(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int unsigned lat_of(input logic [1:0] o);
    case (o)
      2'b00:   return G + 2;
      2'b11:   return 1;
      default: return P + R;
    endcase
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_busy = 0; m_ready = 0; m_done = 0; m_err = 0; m_d = 0; m_t = 0;
    end else begin
      m_done = 0;
      m_err  = 0;
      if (m_busy) begin
        m_t++;
        if (m_t > lat_of(m_op)) begin
          m_busy = 0; m_done = 1; m_err = (m_op == 2'b11); m_ready = 1;
        end
      end else if (m_ready && bus.REQ_VALID) begin
        m_busy = 1; m_t = 1; m_op = bus.REQ_OP; m_ready = 0;
        case (bus.REQ_OP)
          2'b00: m_d = bus.REQ_DATA;
          2'b01: m_d = 1;
          2'b10: m_d = 0;
          default: ;
        endcase
      end else begin
        m_ready = 1;
      end
    end
  endtask

  task automatic check_cycle();
    bit e_clk, e_setb, e_rstb;
    e_clk  = m_busy && (m_op == 2'b00) && (m_t >= 2) && (m_t <= G + 1);
    e_setb = !(m_busy && (m_op == 2'b01) && (m_t <= P));
    e_rstb = !(m_busy && (m_op == 2'b10) && (m_t <= P));
    chk("REQ_READY", bus.REQ_READY, m_ready);
    chk("DONE", bus.DONE, m_done);
    chk("ERR", bus.ERR, m_err);
    chk("BUSY", bus.BUSY, m_busy);
    chk("LAT_D", lat_d, m_d);
    chk("LAT_CLK", lat_clk, e_clk);
    chk("LAT_SETB", lat_setb, e_setb);
    chk("LAT_RSTB", lat_rstb, e_rstb);
    chk("inv_setb_rstb_not_both_low", lat_setb | lat_rstb, 1'b1);
    chk("inv_clk_low_during_pulse", lat_clk & ~(lat_setb & lat_rstb), 1'b0);
    if (p_clk || lat_clk) chk("inv_d_stable_while_gate", lat_d, p_d);
    p_clk = lat_clk;
    p_d   = lat_d;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_cycle();
  endtask

  task automatic drive(input logic v, input logic [1:0] o, input logic dd);
    bus.REQ_VALID = v;
    bus.REQ_OP    = o;
    bus.REQ_DATA  = dd;
  endtask

  initial begin
    drive(1'b0, 2'b00, 1'b0);
    rst = 1'b1;

    // Reset then idle
    repeat (3) step();
    chk("rst_ready", bus.REQ_READY, 1'b0);
    chk("rst_setb", lat_setb, 1'b1);
    rst = 1'b0;
    step();
    chk("idle_ready", bus.REQ_READY, 1'b1);
    chk("idle_busy", bus.BUSY, 1'b0);

    // Write 1: accepted at edge n
    drive(1'b1, 2'b00, 1'b1);
    step();
    drive(1'b0, 2'b00, 1'b0);
    chk("wr_n1_d", lat_d, 1'b1);
    chk("wr_n1_clk", lat_clk, 1'b0);
    step();
    chk("wr_n2_clk", lat_clk, 1'b1);
    step();
    chk("wr_n3_clk", lat_clk, 1'b0);
    step();
    chk("wr_n4_done", bus.DONE, 1'b1);
    chk("wr_n4_ready", bus.REQ_READY, 1'b1);
    step();
    chk("wr_n5_done", bus.DONE, 1'b0);

    // Set then reset back-to-back; OP switches to reset while busy
    drive(1'b1, 2'b01, 1'b0);
    step();
    drive(1'b1, 2'b10, 1'b0);
    chk("set_n1_setb", lat_setb, 1'b0);
    chk("set_n1_d", lat_d, 1'b1);
    step();
    chk("set_n2_setb", lat_setb, 1'b0);
    step();
    chk("set_n3_setb", lat_setb, 1'b1);
    step();
    chk("set_n4_done", bus.DONE, 1'b1);
    step();
    drive(1'b0, 2'b00, 1'b0);
    chk("rst_n5_rstb", lat_rstb, 1'b0);
    chk("rst_n5_d", lat_d, 1'b0);
    step();
    chk("rst_n6_rstb", lat_rstb, 1'b0);
    step();
    chk("rst_n7_rstb", lat_rstb, 1'b1);
    step();
    chk("rst_n8_done", bus.DONE, 1'b1);
    step();

    // Reserved op
    drive(1'b1, 2'b11, 1'b1);
    step();
    drive(1'b0, 2'b00, 1'b0);
    chk("rsv_n1_busy", bus.BUSY, 1'b1);
    chk("rsv_n1_d", lat_d, 1'b0);
    step();
    chk("rsv_n2_done", bus.DONE, 1'b1);
    chk("rsv_n2_err", bus.ERR, 1'b1);
    chk("rsv_n2_ready", bus.REQ_READY, 1'b1);
    step();
    chk("rsv_n3_err", bus.ERR, 1'b0);

    // Reset in the middle of a set pulse
    drive(1'b1, 2'b01, 1'b0);
    step();
    drive(1'b0, 2'b00, 1'b0);
    chk("abort_n1_setb", lat_setb, 1'b0);
    rst = 1'b1;
    step();
    chk("abort_setb", lat_setb, 1'b1);
    chk("abort_done", bus.DONE, 1'b0);
    chk("abort_busy", bus.BUSY, 1'b0);
    rst = 1'b0;
    step();
    chk("abort_ready", bus.REQ_READY, 1'b1);
    repeat (4) step();

    // VALID held with changing OP while busy: one write of 0 only
    ndone = 0;
    drive(1'b1, 2'b00, 1'b0);
    step();
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 2'(i), 1'b1);
      step();
      if (bus.DONE) ndone++;
    end
    drive(1'b0, 2'b00, 1'b0);
    repeat (3) begin
      step();
      if (bus.DONE) ndone++;
    end
    chk("hold_valid_one_done", ndone == 1, 1'b1);
    chk("hold_valid_d", lat_d, 1'b0);

    // Random traffic checked by the model every cycle
    for (int i = 0; i < 80; i++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      step();
    end
    drive(1'b0, 2'b00, 1'b0);
    repeat (8) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
